// File: rtl/alu_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_ctrl
//  Description : Command-side controller for an external 16-bit combinational
//                ALU. Accepts one command per handshake, fetches operands from
//                a small register file, captures the ALU result, writes it back
//                and returns it on a valid/ready response channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_ctrl #(
  parameter  int WIDTH = 16,
  parameter  int NREGS = 4,
  localparam int RAW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  // command channel
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [RAW-1:0]   cmd_dst,
  input  logic [RAW-1:0]   cmd_src_a,
  input  logic [RAW-1:0]   cmd_src_b,
  input  logic             cmd_imm_en,
  input  logic [WIDTH-1:0] cmd_imm,
  // external ALU
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out,
  // response channel
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  // debug read port
  input  logic [RAW-1:0]   rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [2:0] OP_ZERO = 3'b111;

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [2:0]       alu_op_q;
  logic [RAW-1:0]   dst_q;
  logic [WIDTH-1:0] result_q;
  logic             accept_w;

  assign accept_w = cmd_valid && cmd_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: EXEC lasts exactly one cycle, RESP waits for the consumer
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept_w)  state_d = ST_EXEC;
      ST_EXEC:                state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state
  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE: cmd_ready = 1'b1;
      ST_RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand capture at accept; operands read pre-writeback values so dst==src sees the old value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= OP_ZERO;
      dst_q    <= '0;
    end else if (state_q == ST_IDLE && accept_w) begin
      alu_a_q  <= regs_q[cmd_src_a];
      alu_b_q  <= cmd_imm_en ? cmd_imm : regs_q[cmd_src_b];
      alu_op_q <= cmd_op;
      dst_q    <= cmd_dst;
    end
  end

  // Result capture and register-file writeback at the closing edge of EXEC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (state_q == ST_EXEC) begin
      result_q      <= alu_out;
      regs_q[dst_q] <= alu_out;
    end
  end

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_op   = alu_op_q;
  assign rsp_data = result_q;
  assign rsp_zero = (result_q == '0);
  assign rd_data  = regs_q[rd_addr];

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_cmd_ctrl
//  Description : Directed self-checking bench for alu_cmd_ctrl with a
//                behavioural ALU and a queue of expected responses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_ctrl;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [1:0]  cmd_dst;
  logic [1:0]  cmd_src_a;
  logic [1:0]  cmd_src_b;
  logic        cmd_imm_en;
  logic [15:0] cmd_imm;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_op;
  logic [15:0] alu_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_zero;
  logic [1:0]  rd_addr;
  logic [15:0] rd_data;

  int n_asserts = 0;
  int n_fail    = 0;
  logic [15:0] exp_q [$];

  alu_cmd_ctrl #(.WIDTH(16), .NREGS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_dst   (cmd_dst),
    .cmd_src_a (cmd_src_a),
    .cmd_src_b (cmd_src_b),
    .cmd_imm_en(cmd_imm_en),
    .cmd_imm   (cmd_imm),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_out   (alu_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_zero  (rsp_zero),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  // Behavioural model of the external combinational ALU
  always_comb begin
    alu_out = 16'h0000;
    case (alu_op)
      3'b000: alu_out = alu_a & alu_b;
      3'b001: alu_out = alu_a | alu_b;
      3'b010: alu_out = alu_a + alu_b;
      3'b011: alu_out = alu_a - alu_b;
      3'b100: alu_out = {alu_a[14:0], 1'b0};
      3'b101: alu_out = {1'b0, alu_a[15:1]};
      3'b110: alu_out = {alu_a[15], alu_a[15:1]};
      default: alu_out = 16'h0000;
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input logic [1:0] addr, input logic [15:0] exp);
    rd_addr = addr;
    #1;
    chk($sformatf("rd_data_R%0d", addr), {16'h0, rd_data}, {16'h0, exp});
  endtask

  // Drives one command and returns at the falling edge inside EXEC
  task automatic issue(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] sa,
                       input logic [1:0] sb, input logic ie, input logic [15:0] imm);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst;
    cmd_src_a = sa; cmd_src_b = sb; cmd_imm_en = ie; cmd_imm = imm;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_idle", {31'h0, cmd_ready}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("exec_rsp_valid_low", {31'h0, rsp_valid}, 32'h0);
    chk("exec_alu_op", {29'h0, alu_op}, {29'h0, op});
  endtask

  // Waits for the response, checks latency and data, completes the handshake
  task automatic collect(input string tag);
    int n;
    logic [15:0] e;
    rsp_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, 0);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_nonempty"}, 32'h0, 32'h1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_data"}, {16'h0, rsp_data}, {16'h0, e});
      chk({tag, "_zero"}, {31'h0, rsp_zero}, {31'h0, (e == 16'h0)});
    end
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_rsp_done"}, {31'h0, rsp_valid}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'b000; cmd_dst = 2'd0;
    cmd_src_a = 2'd0; cmd_src_b = 2'd0; cmd_imm_en = 1'b0; cmd_imm = 16'h0;
    rsp_ready = 1'b0; rd_addr = 2'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_alu_op", {29'h0, alu_op}, 32'h7);
    chk("rst_alu_a", {16'h0, alu_a}, 32'h0);
    chk("rst_rsp_data", {16'h0, rsp_data}, 32'h0);
    for (int i = 0; i < 4; i++) chk_reg(2'(i), 16'h0000);

    // Immediate load
    exp_q.push_back(16'h1234); issue(3'b001, 2'd1, 2'd0, 2'd0, 1'b1, 16'h1234); collect("imm_load");
    chk_reg(2'd1, 16'h1234);

    // Wrap and zero flag
    exp_q.push_back(16'h0001); issue(3'b001, 2'd2, 2'd0, 2'd0, 1'b1, 16'h0001); collect("load_r2");
    exp_q.push_back(16'hFFFF); issue(3'b011, 2'd3, 2'd0, 2'd2, 1'b0, 16'h0000); collect("sub_wrap");
    chk_reg(2'd3, 16'hFFFF);
    exp_q.push_back(16'h0000); issue(3'b011, 2'd3, 2'd3, 2'd3, 1'b0, 16'h0000); collect("sub_self");
    exp_q.push_back(16'h0002); issue(3'b010, 2'd3, 2'd2, 2'd2, 1'b0, 16'h0000); collect("add_regs");
    chk_reg(2'd3, 16'h0002);

    // Shifts, logic, wrap on ADD, ZERO op
    exp_q.push_back(16'h8001); issue(3'b001, 2'd1, 2'd0, 2'd0, 1'b1, 16'h8001); collect("load_r1");
    exp_q.push_back(16'h0002); issue(3'b100, 2'd2, 2'd1, 2'd0, 1'b0, 16'h0000); collect("shl1");
    exp_q.push_back(16'h4000); issue(3'b101, 2'd2, 2'd1, 2'd0, 1'b0, 16'h0000); collect("shr1");
    exp_q.push_back(16'hC000); issue(3'b110, 2'd2, 2'd1, 2'd0, 1'b0, 16'h0000); collect("sar1");
    chk_reg(2'd2, 16'hC000);
    exp_q.push_back(16'h0001); issue(3'b000, 2'd3, 2'd1, 2'd0, 1'b1, 16'h00FF); collect("and_imm");
    exp_q.push_back(16'h0001); issue(3'b010, 2'd0, 2'd1, 2'd0, 1'b1, 16'h8000); collect("add_wrap");
    exp_q.push_back(16'h0000); issue(3'b111, 2'd1, 2'd1, 2'd1, 1'b0, 16'h0000); collect("zero_op");
    chk_reg(2'd1, 16'h0000);
    chk_reg(2'd0, 16'h0001);

    // Backpressure: R2 = R0 + R3 = 2, then a held command R3 = R2 - 3 = 0xFFFF
    exp_q.push_back(16'h0002);
    issue(3'b010, 2'd2, 2'd0, 2'd3, 1'b0, 16'h0000);
    rsp_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'b011; cmd_dst = 2'd3;
    cmd_src_a = 2'd2; cmd_src_b = 2'd0; cmd_imm_en = 1'b1; cmd_imm = 16'h0003;
    exp_q.push_back(16'hFFFF);
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", {31'h0, rsp_valid}, 32'h1);
      chk("bp_rsp_data", {16'h0, rsp_data}, {16'h0, exp_q[0]});
      chk("bp_cmd_ready", {31'h0, cmd_ready}, 32'h0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    chk("bp_data_final", {16'h0, rsp_data}, {16'h0, exp_q.pop_front()});
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_idle_ready", {31'h0, cmd_ready}, 32'h1);
    chk("bp_idle_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp_second_accepted", {31'h0, cmd_ready}, 32'h0);
    chk("bp_second_op", {29'h0, alu_op}, 32'h3);
    collect("bp_second");
    chk_reg(2'd3, 16'hFFFF);

    // Reset during EXEC drops the command
    issue(3'b010, 2'd1, 2'd0, 2'd0, 1'b1, 16'h5555);
    rst = 1'b1;
    #1;
    chk("midrst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("midrst_no_rsp", {31'h0, rsp_valid}, 32'h0);
      chk("midrst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
      @(negedge clk);
    end
    chk_reg(2'd1, 16'h0000);
    chk("midrst_alu_op", {29'h0, alu_op}, 32'h7);
    chk("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
